// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and price table for the vending controller
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAY,
    DISPENSE,
    CHANGE,
    REFUND
  } state_t;

  typedef logic [1:0] item_idx_t;

  localparam int TABLE_W = 4;
  localparam logic [TABLE_W-1:0] PRICE_TABLE [4] = '{4'd1, 4'd2, 4'd3, 4'd5};

endpackage

// File: rtl/vending_timer.sv
// rtl/vending_timer.sv - loadable down-counter; expire flags the last enabled cycle
module vending_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == W'(1));

endmodule

// File: rtl/vending_fsm.sv
// rtl/vending_fsm.sv - vending controller: selection, credit tracking, vend and change/refund
module vending_fsm
  import vending_pkg::*;
#(
  parameter int PRICE_W         = 4,
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         item_sel,
  input  logic               sel_valid,
  input  logic               coin_valid,
  input  logic [PRICE_W-1:0] coin_value,
  input  logic               cancel,
  output logic [PRICE_W-1:0] item_price,
  output logic [PRICE_W-1:0] credit,
  output logic               dispense,
  output logic [1:0]         dispense_item,
  output logic               change_valid,
  output logic [PRICE_W-1:0] change_amt,
  output logic               coin_reject,
  output logic               busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DC_W = $clog2(DISPENSE_CYCLES + 1);

  state_t             state, state_nxt;
  item_idx_t          item_q;
  logic [PRICE_W-1:0] price_q, credit_q;
  logic               reject_q;

  logic               coin, fits, accept, paid;
  logic [PRICE_W:0]   sum;
  logic               to_expire, dc_expire;
  logic [PRICE_W-1:0] diff;

  assign coin   = coin_valid && (coin_value != '0);
  assign sum    = {1'b0, credit_q} + {1'b0, coin_value};
  assign fits   = !sum[PRICE_W];
  assign accept = (state == PAY) && coin && fits;
  assign paid   = accept && (sum[PRICE_W-1:0] >= price_q);

  // An accepted coin holds off the timeout enable, so the coin always wins a tie.
  vending_timer #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (((state == IDLE) && sel_valid) || accept),
    .load_val (TO_W'(TIMEOUT_CYCLES)),
    .en       ((state == PAY) && !accept),
    .expire   (to_expire)
  );

  vending_timer #(.W(DC_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (paid),
    .load_val (DC_W'(DISPENSE_CYCLES)),
    .en       (state == DISPENSE),
    .expire   (dc_expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sel_valid) state_nxt = PAY;
      PAY: begin
        if (paid)                        state_nxt = DISPENSE;
        else if (cancel || to_expire)    state_nxt = REFUND;
      end
      DISPENSE: if (dc_expire) state_nxt = CHANGE;
      CHANGE:   state_nxt = IDLE;
      REFUND:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      item_q   <= '0;
      price_q  <= '0;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      reject_q <= coin && ((state != PAY) || !fits);
      if (state == IDLE && sel_valid) begin
        item_q   <= item_sel;
        price_q  <= PRICE_W'(PRICE_TABLE[item_sel]);
        credit_q <= '0;
      end else if (accept) begin
        credit_q <= sum[PRICE_W-1:0];
      end else if (state == CHANGE || state == REFUND) begin
        price_q  <= '0;
        credit_q <= '0;
      end
    end
  end

  assign diff          = credit_q - price_q;
  assign item_price    = price_q;
  assign credit        = credit_q;
  assign dispense      = (state == DISPENSE);
  assign dispense_item = dispense ? item_q : 2'd0;
  assign coin_reject   = reject_q;
  assign busy          = (state != IDLE);

  always_comb begin
    change_valid = 1'b0;
    change_amt   = '0;
    if (state == CHANGE && diff != '0) begin
      change_valid = 1'b1;
      change_amt   = diff;
    end else if (state == REFUND && credit_q != '0) begin
      change_valid = 1'b1;
      change_amt   = credit_q;
    end
  end

endmodule

// File: tb/tb_vending_fsm.sv
// tb/tb_vending_fsm.sv - randomized and directed checks of vending_fsm against a transaction model
module tb_vending_fsm;

  localparam int PW = 4;
  localparam int DC = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    item_sel = '0;
  logic          sel_valid = 1'b0;
  logic          coin_valid = 1'b0;
  logic [PW-1:0] coin_value = '0;
  logic          cancel = 1'b0;
  logic [PW-1:0] item_price, credit, change_amt;
  logic          dispense, change_valid, coin_reject, busy;
  logic [1:0]    dispense_item;

  vending_fsm #(.PRICE_W(PW), .DISPENSE_CYCLES(DC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .item_sel(item_sel), .sel_valid(sel_valid),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .item_price(item_price), .credit(credit), .dispense(dispense),
    .dispense_item(dispense_item), .change_valid(change_valid),
    .change_amt(change_amt), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: an open transaction, a remaining vend count,
  // and a pending settlement amount (-1 when nothing is being settled).
  int price_tab [4] = '{1, 2, 3, 5};
  int m_active, m_price, m_credit, m_item, m_disp_left, m_settle, m_idle, m_rej;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_price = 0; m_credit = 0; m_item = 0;
    m_disp_left = 0; m_settle = -1; m_idle = 0; m_rej = 0;
  endtask

  task automatic model_step();
    int is_coin;
    int val;
    int rej;
    is_coin = (coin_valid && coin_value != 0) ? 1 : 0;
    val = int'(coin_value);
    rej = 0;
    if (m_settle >= 0) begin
      m_settle = -1; m_active = 0; m_price = 0; m_credit = 0;
      rej = is_coin;
    end else if (m_disp_left > 0) begin
      m_disp_left--;
      if (m_disp_left == 0) m_settle = m_credit - m_price;
      rej = is_coin;
    end else if (m_active != 0) begin
      if (is_coin != 0 && m_credit + val > (1 << PW) - 1) rej = 1;
      if (is_coin != 0 && rej == 0) begin
        m_credit += val;
        m_idle = 0;
        if (m_credit >= m_price) m_disp_left = DC;
      end else begin
        m_idle++;
      end
      if (m_disp_left == 0 && (cancel || m_idle >= TO)) m_settle = m_credit;
    end else begin
      if (sel_valid) begin
        m_active = 1; m_item = int'(item_sel);
        m_price = price_tab[item_sel]; m_credit = 0; m_idle = 0;
      end
      rej = is_coin;
    end
    m_rej = rej;
  endtask

  task automatic compare();
    int cv;
    cv = (m_settle > 0) ? 1 : 0;
    chk("item_price", int'(item_price), m_price);
    chk("credit", int'(credit), m_credit);
    chk("dispense", int'(dispense), (m_disp_left > 0) ? 1 : 0);
    chk("dispense_item", int'(dispense_item), (m_disp_left > 0) ? m_item : 0);
    chk("change_valid", int'(change_valid), cv);
    chk("change_amt", int'(change_amt), cv ? m_settle : 0);
    chk("coin_reject", int'(coin_reject), m_rej);
    chk("busy", int'(busy), m_active);
  endtask

  task automatic cyc(input int s, input int it, input int cv, input int v, input int c);
    item_sel   = 2'(it);
    sel_valid  = 1'(s);
    coin_valid = 1'(cv);
    coin_value = PW'(v);
    cancel     = 1'(c);
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_price", int'(item_price), 0);
    chk("reset_dispense", int'(dispense), 0);
    #10 rst_n = 1'b1;

    // exact payment
    cyc(1, 1, 0, 0, 0);
    chk("exact_price", int'(item_price), 2);
    cyc(0, 0, 1, 2, 0);
    chk("exact_dispense", int'(dispense), 1);
    chk("exact_item", int'(dispense_item), 1);
    idle_cycles(3);
    cyc(0, 0, 0, 0, 0);
    chk("exact_no_change", int'(change_valid), 0);
    cyc(0, 0, 0, 0, 0);
    chk("exact_price_clear", int'(item_price), 0);

    // overpay
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(0, 0, 1, 2, 0);
    chk("over_credit", int'(credit), 4);
    idle_cycles(3);
    cyc(0, 0, 0, 0, 0);
    chk("over_change_valid", int'(change_valid), 1);
    chk("over_change_amt", int'(change_amt), 1);
    cyc(0, 0, 0, 0, 0);

    // cancel with refund
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 1);
    chk("cancel_change_amt", int'(change_amt), 2);
    chk("cancel_dispense", int'(dispense), 0);
    cyc(0, 0, 0, 0, 0);
    chk("cancel_busy", int'(busy), 0);

    // overflow rejection, then refund of the retained credit
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, 15, 0);
    chk("ovf_reject", int'(coin_reject), 1);
    chk("ovf_credit", int'(credit), 4);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_refund", int'(change_amt), 4);
    cyc(0, 0, 0, 0, 0);

    // 4+4 covers price 5 on the second coin
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 1, 4, 0);
    chk("ovr_dispense", int'(dispense), 1);
    cyc(0, 0, 1, 4, 0);
    chk("disp_coin_reject", int'(coin_reject), 1);
    idle_cycles(2);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_change_amt", int'(change_amt), 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 0);
    chk("idle_coin_reject", int'(coin_reject), 1);

    // timeout, then timeout despite a zero-value coin
    cyc(1, 0, 0, 0, 0);
    idle_cycles(TO - 1);
    chk("to_still_pay", int'(busy), 1);
    cyc(0, 0, 0, 0, 0);
    chk("to_refund_busy", int'(busy), 1);
    chk("to_no_change", int'(change_valid), 0);
    cyc(0, 0, 0, 0, 0);
    chk("to_idle", int'(busy), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle_cycles(TO - 1);
    chk("to0_refund", int'(busy), 1);
    cyc(0, 0, 0, 0, 0);
    chk("to0_idle", int'(busy), 0);

    // reset in the second dispense cycle
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_price", int'(item_price), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    model_reset();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("rst_no_change", int'(change_valid), 0);
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int v;
      v = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 6));
      cyc(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0) ? 1 : 0, v,
          ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
